clock_phase_ctrl: RTL and testbench

Parametrised processor clock/phase controller replacing the fixed divide-by-four clock divider in the top-level wrapper. From the single master clock it generates the divided processor/regfile clock, its complement, a per-period phase index and an end-of-period tick. It adds run/halt/single-step control with a retired-period counter, so benches and debug logic can freeze the processor on a clean period boundary. It sits between the top-level clock input and every clocked element of the processor.

---
 rtl/clock_phase_ctrl.sv | 123 ++++++++++++
 tb/tb_clock_phase_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/clock_phase_ctrl.sv
// ---------------------------------------------------------------------------
// clock_phase_ctrl
//   Divides the master clock into a processor/regfile clock of DIV master
//   cycles per period. It also provides a phase index, an end-of-period tick
//   and run / halt / single-step control. Halting only takes effect on a
//   period boundary, so the processor always freezes cleanly. A counter
//   records each active period that completes.
//
// Parameters
//   DIV    master-clock cycles per processor period (even, >= 2)
//   CYC_W  width of cycle_count
//
// Ports
//   clock         in   master clock, rising-edge active
//   reset         in   synchronous active-high reset, overrides everything
//   halt          in   level: stop at next period boundary, stay stopped
//   step          in   pulse: run one period, honoured only while halted
//   proc_clock    out  divided clock (low half then high half), registered
//   proc_clock_n  out  exact complement of proc_clock, registered
//   phase         out  position within the current period
//   tick          out  high during the last cycle of an active period
//   halted        out  high while halted
//   cycle_count   out  completed active periods (wraps)
// ---------------------------------------------------------------------------
module clock_phase_ctrl #(
  parameter int unsigned DIV   = 4,
  parameter int unsigned CYC_W = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     halt,
  input  logic                     step,
  output logic                     proc_clock,
  output logic                     proc_clock_n,
  output logic [$clog2(DIV)-1:0]   phase,
  output logic                     tick,
  output logic                     halted,
  output logic [CYC_W-1:0]         cycle_count
);

  localparam int unsigned PW = $clog2(DIV);
  localparam logic [PW-1:0] PHASE_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] PHASE_HALF = PW'(DIV / 2);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_STEP   = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [PW-1:0]      phase_nxt;
  logic [CYC_W-1:0]   count_nxt;
  logic               wrap;
  logic               active_nxt;
  logic               proc_clock_nxt;
  logic               tick_nxt;

  // Next-state and next-output computation.
  always_comb begin
    state_nxt      = state;
    phase_nxt      = phase;
    count_nxt      = cycle_count;
    wrap           = (state != ST_HALTED) && (phase == PHASE_LAST);
    active_nxt     = 1'b1;
    proc_clock_nxt = 1'b0;
    tick_nxt       = 1'b0;

    case (state)
      ST_RUN, ST_STEP: begin
        // halt is only examined on the wrap edge; step is never examined here.
        if (wrap) begin
          phase_nxt = '0;
          count_nxt = cycle_count + CYC_W'(1);
          state_nxt = halt ? ST_HALTED : ST_RUN;
        end else begin
          phase_nxt = phase + PW'(1);
        end
      end
      ST_HALTED: begin
        // Leaving HALTED keeps phase at 0 for the first cycle of the new period.
        phase_nxt = '0;
        if (!halt) begin
          state_nxt = ST_RUN;
        end else if (step) begin
          state_nxt = ST_STEP;
        end
      end
      default: begin
        state_nxt = ST_RUN;
        phase_nxt = '0;
      end
    endcase

    // Outputs are registered, so they are derived from the next phase/state.
    active_nxt     = (state_nxt != ST_HALTED);
    proc_clock_nxt = active_nxt && (phase_nxt >= PHASE_HALF);
    tick_nxt       = active_nxt && (phase_nxt == PHASE_LAST);
  end

  // State and output registers; proc_clock_n is loaded from the same next value.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_RUN;
      phase        <= '0;
      proc_clock   <= 1'b0;
      proc_clock_n <= 1'b1;
      tick         <= 1'b0;
      halted       <= 1'b0;
      cycle_count  <= '0;
    end else begin
      state        <= state_nxt;
      phase        <= phase_nxt;
      proc_clock   <= proc_clock_nxt;
      proc_clock_n <= ~proc_clock_nxt;
      tick         <= tick_nxt;
      halted       <= ~active_nxt;
      cycle_count  <= count_nxt;
    end
  end

endmodule

// File: tb/tb_clock_phase_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clock_phase_ctrl
//   Drives three instances (DIV=4/CYC_W=32, DIV=6/CYC_W=3, DIV=2/CYC_W=8)
//   from one random stimulus stream. A behavioural model predicts each
//   instance's outputs per edge into a queue; a monitor compares them.
// ---------------------------------------------------------------------------
module tb_clock_phase_ctrl;

  localparam int NINST = 3;
  localparam int MODE_RUN    = 0;
  localparam int MODE_HALTED = 1;
  localparam int MODE_STEP   = 2;

  logic clock;
  logic reset;
  logic halt;
  logic step;

  logic       pc4, pcn4, tick4, hlt4;
  logic [1:0] ph4;
  logic [31:0] cnt4;
  logic       pc6, pcn6, tick6, hlt6;
  logic [2:0] ph6;
  logic [2:0] cnt6;
  logic       pc2, pcn2, tick2, hlt2;
  logic [0:0] ph2;
  logic [7:0] cnt2;

  clock_phase_ctrl #(.DIV(4), .CYC_W(32)) u_div4 (
    .clock(clock), .reset(reset), .halt(halt), .step(step),
    .proc_clock(pc4), .proc_clock_n(pcn4), .phase(ph4), .tick(tick4),
    .halted(hlt4), .cycle_count(cnt4)
  );

  clock_phase_ctrl #(.DIV(6), .CYC_W(3)) u_div6 (
    .clock(clock), .reset(reset), .halt(halt), .step(step),
    .proc_clock(pc6), .proc_clock_n(pcn6), .phase(ph6), .tick(tick6),
    .halted(hlt6), .cycle_count(cnt6)
  );

  clock_phase_ctrl #(.DIV(2), .CYC_W(8)) u_div2 (
    .clock(clock), .reset(reset), .halt(halt), .step(step),
    .proc_clock(pc2), .proc_clock_n(pcn2), .phase(ph2), .tick(tick2),
    .halted(hlt2), .cycle_count(cnt2)
  );

  typedef struct {
    int              inst;
    int              ph;
    bit              pc;
    bit              pcn;
    bit              tk;
    bit              hl;
    longint unsigned cnt;
  } exp_t;

  exp_t exp_q[$];

  int              n_checks = 0;
  int              n_fail   = 0;
  bit              stim_done = 1'b0;

  // Reference model: operating mode, position in period, completed periods.
  int              div_of [NINST] = '{4, 6, 2};
  longint unsigned mask_of[NINST] = '{64'hFFFF_FFFF, 64'h7, 64'hFF};
  int              mode   [NINST];
  int              pos    [NINST];
  longint unsigned count  [NINST];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Advance every model by one master edge and queue the predicted outputs.
  task automatic model_edge(input bit r, input bit h, input bit s);
    exp_t e;
    for (int k = 0; k < NINST; k++) begin
      if (r) begin
        mode[k]  = MODE_RUN;
        pos[k]   = 0;
        count[k] = 0;
      end else if (mode[k] == MODE_HALTED) begin
        pos[k] = 0;
        if (!h)     mode[k] = MODE_RUN;
        else if (s) mode[k] = MODE_STEP;
      end else if (pos[k] == div_of[k] - 1) begin
        pos[k]   = 0;
        count[k] = (count[k] + 1) & mask_of[k];
        mode[k]  = h ? MODE_HALTED : MODE_RUN;
      end else begin
        pos[k] = pos[k] + 1;
      end
      e.inst = k;
      e.ph   = pos[k];
      e.hl   = (mode[k] == MODE_HALTED);
      e.pc   = !e.hl && (pos[k] >= div_of[k] / 2);
      e.pcn  = !e.pc;
      e.tk   = !e.hl && (pos[k] == div_of[k] - 1);
      e.cnt  = count[k];
      exp_q.push_back(e);
    end
  endtask

  task automatic cycle(input bit r, input bit h, input bit s);
    @(negedge clock);
    reset = r;
    halt  = h;
    step  = s;
    @(posedge clock);
    model_edge(r, h, s);
  endtask

  // Stimulus: reset, a directed free run, then random halt levels,
  // step pulses and occasional resets.
  initial begin
    int  hold_left;
    bit  h_v;
    reset = 1'b1;
    halt  = 1'b0;
    step  = 1'b0;
    @(posedge clock);
    model_edge(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0);
    hold_left = 0;
    h_v       = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if (hold_left == 0) begin
        h_v       = 1'($urandom_range(0, 1));
        hold_left = (h_v && $urandom_range(0, 2) == 0) ? int'($urandom_range(10, 40))
                                                       : int'($urandom_range(1, 6));
      end
      hold_left = hold_left - 1;
      cycle(1'($urandom_range(0, 249) == 0), h_v,
            1'($urandom_range(0, 3) == 0));
    end
    cycle(1'b0, 1'b0, 1'b0);
    stim_done = 1'b1;
  end

  function automatic exp_t actual_of(input int k);
    exp_t a;
    a.inst = k;
    case (k)
      0: begin a.ph = int'(ph4); a.pc = pc4; a.pcn = pcn4; a.tk = tick4;
               a.hl = hlt4; a.cnt = 64'(cnt4); end
      1: begin a.ph = int'(ph6); a.pc = pc6; a.pcn = pcn6; a.tk = tick6;
               a.hl = hlt6; a.cnt = 64'(cnt6); end
      default: begin a.ph = int'(ph2); a.pc = pc2; a.pcn = pcn2; a.tk = tick2;
               a.hl = hlt2; a.cnt = 64'(cnt2); end
    endcase
    return a;
  endfunction

  // Monitor: outputs are presented every cycle; compare #1 after the edge.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(posedge clock);
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = actual_of(e.inst);
        n_checks++;
        if (a.ph !== e.ph || a.pc !== e.pc || a.pcn !== e.pcn || a.tk !== e.tk ||
            a.hl !== e.hl || a.cnt !== e.cnt) begin
          n_fail++;
          $display("FAIL outputs div=%0d t=%0t: got ph=%0d pc=%0b pcn=%0b tick=%0b halted=%0b cnt=%0d, want ph=%0d pc=%0b pcn=%0b tick=%0b halted=%0b cnt=%0d",
                   div_of[e.inst], $time, a.ph, a.pc, a.pcn, a.tk, a.hl, a.cnt,
                   e.ph, e.pc, e.pcn, e.tk, e.hl, e.cnt);
        end
      end
    end
  end

  // Completion with a bounded wait; an expired bound is a failure.
  initial begin
    int waited;
    waited = 0;
    while (!stim_done && waited < 20000) begin
      @(posedge clock);
      waited++;
    end
    repeat (2) @(posedge clock);
    #2;
    n_checks++;
    if (!stim_done || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL completion: stim_done=%0b pending=%0d, want stim_done=1 pending=0",
               stim_done, exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
